divisor_secuencial: RTL and testbench

Sequential restoring divider that performs the inverse operation of the team's shift-add multiplier (multiplicador): it divides a 32-bit dividend by a 16-bit divisor and returns quotient and remainder. It uses the same iniciar/terminado start-done handshake, so it drops into the calculator datapath next to the multiplier. It retires one quotient bit per clock.

---
 rtl/divisor_secuencial.sv | 134 +++++++++++++
 tb/tb_divisor_secuencial.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : divisor_secuencial
// Brief    : Restoring divider producing one quotient bit per clock, with an
//            iniciar/terminado handshake and a divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module divisor_secuencial #(
    parameter int ANCHO_DIVIDENDO = 32,
    parameter int ANCHO_DIVISOR   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iniciar,
    input  logic [ANCHO_DIVIDENDO-1:0] dividendo,
    input  logic [ANCHO_DIVISOR-1:0]   divisor,
    output logic [ANCHO_DIVIDENDO-1:0] cociente,
    output logic [ANCHO_DIVISOR-1:0]   residuo,
    output logic                       terminado,
    output logic                       ocupado,
    output logic                       div_cero
);

    localparam int ANCHO_CNT = $clog2(ANCHO_DIVIDENDO + 1);
    localparam logic [ANCHO_CNT-1:0] C_ULTIMA = ANCHO_CNT'(ANCHO_DIVIDENDO - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t                    estado_q, estado_d;
    logic [ANCHO_DIVIDENDO-1:0] q_q, q_d;
    logic [ANCHO_DIVISOR:0]     r_q, r_d;
    logic [ANCHO_DIVISOR-1:0]   d_q, d_d;
    logic [ANCHO_CNT-1:0]       cnt_q, cnt_d;
    logic [ANCHO_DIVIDENDO-1:0] cociente_q, cociente_d;
    logic [ANCHO_DIVISOR-1:0]   residuo_q, residuo_d;
    logic                       terminado_q, terminado_d;
    logic                       div_cero_q, div_cero_d;

    logic [ANCHO_DIVISOR+1:0]   w_t;
    logic                       w_ge;
    logic [ANCHO_DIVISOR:0]     w_dif;
    logic [ANCHO_DIVISOR:0]     w_r_sig;
    logic [ANCHO_DIVIDENDO-1:0] w_q_sig;

    always_comb begin
        estado_d    = estado_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        cociente_d  = cociente_q;
        residuo_d   = residuo_q;
        terminado_d = 1'b0;
        div_cero_d  = div_cero_q;

        // The partial remainder always stays below the divisor, so the extra
        // headroom bits keep the compare and subtract free of overflow.
        w_t     = {r_q, q_q[ANCHO_DIVIDENDO-1]};
        w_ge    = (w_t >= {2'b00, d_q});
        w_dif   = w_t[ANCHO_DIVISOR:0] - {1'b0, d_q};
        w_r_sig = w_ge ? w_dif : w_t[ANCHO_DIVISOR:0];
        w_q_sig = {q_q[ANCHO_DIVIDENDO-2:0], w_ge};

        case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    if (divisor == '0) begin
                        estado_d    = FIN;
                        cociente_d  = '1;
                        residuo_d   = dividendo[ANCHO_DIVISOR-1:0];
                        div_cero_d  = 1'b1;
                        terminado_d = 1'b1;
                    end else begin
                        estado_d = CALCULO;
                        q_d      = dividendo;
                        r_d      = '0;
                        d_d      = divisor;
                        cnt_d    = '0;
                    end
                end
            end
            CALCULO: begin
                q_d   = w_q_sig;
                r_d   = w_r_sig;
                cnt_d = cnt_q + ANCHO_CNT'(1);
                if (cnt_q == C_ULTIMA) begin
                    estado_d    = FIN;
                    cociente_d  = w_q_sig;
                    residuo_d   = w_r_sig[ANCHO_DIVISOR-1:0];
                    terminado_d = 1'b1;
                    div_cero_d  = 1'b0;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= REPOSO;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            cociente_q  <= '0;
            residuo_q   <= '0;
            terminado_q <= 1'b0;
            div_cero_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            cociente_q  <= cociente_d;
            residuo_q   <= residuo_d;
            terminado_q <= terminado_d;
            div_cero_q  <= div_cero_d;
        end
    end

    assign cociente  = cociente_q;
    assign residuo   = residuo_q;
    assign terminado = terminado_q;
    assign div_cero  = div_cero_q;
    assign ocupado   = (estado_q == CALCULO);

endmodule
`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
`default_nettype none
// Testbench for divisor_secuencial: directed vectors pushed to a scoreboard,
// a monitor compares every terminado pulse against the queue head.
module tb_divisor_secuencial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iniciar = 1'b0;
    logic [31:0] dividendo = '0;
    logic [15:0] divisor = '0;
    logic [31:0] cociente;
    logic [15:0] residuo;
    logic        terminado, ocupado, div_cero;

    divisor_secuencial #(.ANCHO_DIVIDENDO(32), .ANCHO_DIVISOR(16)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar),
        .dividendo(dividendo), .divisor(divisor),
        .cociente(cociente), .residuo(residuo),
        .terminado(terminado), .ocupado(ocupado), .div_cero(div_cero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          cyc;
    } esperado_t;

    esperado_t sb[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every terminado sample must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && terminado) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_terminado: got pulse at cycle %0d expected none", cyc);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                check("cociente", 64'(cociente), 64'(e.q));
                check("residuo", 64'(residuo), 64'(e.r));
                check("div_cero", 64'(div_cero), 64'(e.dz));
                check("latencia", 64'(cyc), 64'(e.cyc));
                check("ocupado_en_fin", 64'(ocupado), 64'd0);
            end
        end
    end

    // Drive one start request at a negedge; accepting edge is the next posedge.
    task automatic lanzar(input logic [31:0] a, input logic [15:0] b);
        iniciar   = 1'b1;
        dividendo = a;
        divisor   = b;
        @(negedge clk);
        iniciar   = 1'b0;
        dividendo = $urandom;
        divisor   = 16'($urandom);
    endtask

    task automatic esperar(input int limite);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limite) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic dividir(input logic [31:0] a, input logic [15:0] b,
                           input logic [31:0] eq, input logic [15:0] er,
                           input logic edz, input int lat);
        sb.push_back('{eq, er, edz, cyc + 1 + lat});
        lanzar(a, b);
        esperar(60);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cociente", 64'(cociente), 64'd0);
        check("reset_residuo", 64'(residuo), 64'd0);
        check("reset_flags", 64'({terminado, ocupado, div_cero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic case with latency and busy check mid-operation.
        sb.push_back('{32'h55, 16'h0, 1'b0, cyc + 1 + 32});
        lanzar(32'h000010EF, 16'h0033);
        check("ocupado_calculo", 64'(ocupado), 64'd1);
        esperar(60);

        dividir(32'hFFFE0001, 16'hFFFF, 32'h0000FFFF, 16'h0, 1'b0, 32);
        dividir(32'hFFFFFFFF, 16'h0001, 32'hFFFFFFFF, 16'h0, 1'b0, 32);
        dividir(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
        dividir(32'd5, 16'd9, 32'd0, 16'd5, 1'b0, 32);

        // Divide by zero: result at the accepting edge itself.
        sb.push_back('{32'hFFFFFFFF, 16'h5678, 1'b1, cyc + 1});
        lanzar(32'h12345678, 16'h0000);
        check("ocupado_div_cero", 64'(ocupado), 64'd0);
        esperar(10);
        dividir(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);

        // iniciar during CALCULO is ignored.
        sb.push_back('{32'd333, 16'd1, 1'b0, cyc + 1 + 32});
        lanzar(32'd1000, 16'd3);
        repeat (9) @(negedge clk);
        lanzar(32'd8, 16'd2);
        esperar(60);

        // iniciar held high: second start on the first REPOSO edge after FIN.
        sb.push_back('{32'd14, 16'd2, 1'b0, cyc + 1 + 32});
        sb.push_back('{32'd14, 16'd2, 1'b0, cyc + 1 + 66});
        iniciar   = 1'b1;
        dividendo = 32'd100;
        divisor   = 16'd7;
        repeat (40) @(negedge clk);
        iniciar = 1'b0;
        esperar(60);

        // Reset mid-operation aborts without terminado.
        lanzar(32'd1000, 16'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cociente", 64'(cociente), 64'd0);
        check("abort_residuo", 64'(residuo), 64'd0);
        check("abort_flags", 64'({terminado, ocupado, div_cero}), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_sin_terminado", 64'(sb.size()), 64'd0);
        dividir(32'd4335, 16'h0055, 32'd51, 16'd0, 1'b0, 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
